// File: rtl/uart_cmd_parser.sv
// Frame parser for a UART byte stream: 0xAA, opcode, x, y[, checksum], with per-byte timeout.
// Define CMD_CHECKSUM_EN to add the trailing checksum byte (5-byte frames); default is 4-byte frames.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int GRID_SIZE      = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RxD_data_ready,
    input  logic [7:0] RxD_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_op,
    output logic [3:0] cmd_x,
    output logic [3:0] cmd_y,
    output logic       frame_error,
    output logic [1:0] err_code
);
    localparam int                CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]       GRID_LIMIT  = GRID_SIZE;
    localparam logic [7:0]        SYNC_BYTE   = 8'hAA;
    localparam logic [1:0]        ERR_RANGE   = 2'b10;
    localparam logic [1:0]        ERR_TIMEOUT = 2'b11;
`ifdef CMD_CHECKSUM_EN
    localparam logic [1:0]        ERR_CHECKSUM = 2'b01;
    typedef enum logic [2:0] {IDLE, OP, X, Y, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, OP, X, Y} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       op_q, op_d;
    logic [7:0]       x_q, x_d;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]       y_q, y_d;
    logic             chk_ok;
`endif
    logic             cmd_valid_q, cmd_valid_d;
    logic             frame_error_q, frame_error_d;
    logic [7:0]       cmd_op_q, cmd_op_d;
    logic [3:0]       cmd_x_q, cmd_x_d;
    logic [3:0]       cmd_y_q, cmd_y_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             frame_done;
    logic [7:0]       frame_y;
    logic             range_ok;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        x_d           = x_q;
`ifdef CMD_CHECKSUM_EN
        y_d           = y_q;
        frame_y       = y_q;
        chk_ok        = ((op_q ^ x_q ^ y_q) == RxD_data);
`else
        frame_y       = RxD_data;
`endif
        cmd_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        cmd_op_d      = cmd_op_q;
        cmd_x_d       = cmd_x_q;
        cmd_y_d       = cmd_y_q;
        err_code_d    = err_code_q;
        frame_done    = 1'b0;
        range_ok      = ({24'd0, x_q} < GRID_LIMIT) && ({24'd0, frame_y} < GRID_LIMIT);

        if (RxD_data_ready) begin
            // Any accepted byte restarts the inter-byte timer, even on the expiry cycle.
            cnt_d = '0;
            case (state_q)
                IDLE: if (RxD_data == SYNC_BYTE) state_d = OP;
                OP: begin
                    op_d    = RxD_data;
                    state_d = X;
                end
                X: begin
                    x_d     = RxD_data;
                    state_d = Y;
                end
`ifdef CMD_CHECKSUM_EN
                Y: begin
                    y_d     = RxD_data;
                    state_d = CHK;
                end
                CHK: begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
`else
                Y: begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LIMIT) begin
                state_d       = IDLE;
                cnt_d         = '0;
                frame_error_d = 1'b1;
                err_code_d    = ERR_TIMEOUT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (frame_done) begin
`ifdef CMD_CHECKSUM_EN
            if (!chk_ok) begin
                frame_error_d = 1'b1;
                err_code_d    = ERR_CHECKSUM;
            end else
`endif
            if (!range_ok) begin
                frame_error_d = 1'b1;
                err_code_d    = ERR_RANGE;
            end else begin
                cmd_valid_d = 1'b1;
                cmd_op_d    = op_q;
                cmd_x_d     = x_q[3:0];
                cmd_y_d     = frame_y[3:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            x_q           <= '0;
`ifdef CMD_CHECKSUM_EN
            y_q           <= '0;
`endif
            cmd_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            cmd_op_q      <= '0;
            cmd_x_q       <= '0;
            cmd_y_q       <= '0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            x_q           <= x_d;
`ifdef CMD_CHECKSUM_EN
            y_q           <= y_d;
`endif
            cmd_valid_q   <= cmd_valid_d;
            frame_error_q <= frame_error_d;
            cmd_op_q      <= cmd_op_d;
            cmd_x_q       <= cmd_x_d;
            cmd_y_q       <= cmd_y_d;
            err_code_q    <= err_code_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign frame_error = frame_error_q;
    assign cmd_op      = cmd_op_q;
    assign cmd_x       = cmd_x_q;
    assign cmd_y       = cmd_y_q;
    assign err_code    = err_code_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: table vectors, hand sequences, randomized frames vs a model.
module tb_uart_cmd_parser;
    localparam int T = 20;
    localparam int G = 10;
`ifdef CMD_CHECKSUM_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rdy;
    logic [7:0] data;
    logic       cmd_valid;
    logic [7:0] cmd_op;
    logic [3:0] cmd_x;
    logic [3:0] cmd_y;
    logic       frame_error;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_errors = 0;

    uart_cmd_parser #(.TIMEOUT_CYCLES(T), .GRID_SIZE(G)) dut (
        .clock(clock), .reset(reset), .RxD_data_ready(rdy), .RxD_data(data),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .frame_error(frame_error), .err_code(err_code)
    );

    always #5 clock = ~clock;

    // Reference model: bytes collected per frame in a queue, timeout from cycle stamps.
    bit         m_in_frame = 1'b0;
    logic [7:0] m_frame [$];
    int         m_cyc = 0;
    int         m_last = 0;
    logic       m_valid = 1'b0, m_ferr = 1'b0;
    logic [7:0] m_op = 8'h00;
    logic [3:0] m_x = 4'h0, m_y = 4'h0;
    logic [1:0] m_code = 2'b00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] d);
        logic [7:0] op, x, y;
        m_cyc++;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        if (r) begin
            m_in_frame = 1'b0;
            m_frame.delete();
            m_op = 8'h00; m_x = 4'h0; m_y = 4'h0; m_code = 2'b00;
        end else if (v) begin
            m_last = m_cyc;
            if (!m_in_frame) begin
                if (d == 8'hAA) begin
                    m_in_frame = 1'b1;
                    m_frame.delete();
                end
            end else begin
                m_frame.push_back(d);
                if (m_frame.size() == FLEN - 1) begin
                    op = m_frame[0]; x = m_frame[1]; y = m_frame[2];
                    m_in_frame = 1'b0;
                    m_ferr = 1'b1;
`ifdef CMD_CHECKSUM_EN
                    if (m_frame[3] != (op ^ x ^ y)) m_code = 2'b01;
                    else
`endif
                    if (int'(x) >= G || int'(y) >= G) m_code = 2'b10;
                    else begin
                        m_ferr = 1'b0; m_valid = 1'b1;
                        m_op = op; m_x = x[3:0]; m_y = y[3:0];
                    end
                    $display("frame op=%02h x=%02h y=%02h -> %s code=%0d", op, x, y,
                             m_valid ? "good" : "rejected", m_code);
                end
            end
        end else if (m_in_frame && (m_cyc - m_last > T)) begin
            m_in_frame = 1'b0;
            m_ferr = 1'b1;
            m_code = 2'b11;
            $display("frame timeout after %0d idle cycles", m_cyc - m_last - 1);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] d);
        reset = r; rdy = v; data = d;
        @(posedge clock);
        model_step(r, v, d);
        #1;
        check("model cmd_valid", 32'(cmd_valid), 32'(m_valid));
        check("model frame_error", 32'(frame_error), 32'(m_ferr));
        check("model cmd_op", 32'(cmd_op), 32'(m_op));
        check("model cmd_x", 32'(cmd_x), 32'(m_x));
        check("model cmd_y", 32'(cmd_y), 32'(m_y));
        check("model err_code", 32'(err_code), 32'(m_code));
    endtask

    task automatic send_vec(input logic [39:0] bytes, input logic good, input string nm);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, bytes[39-8*i -: 8]);
            if (i == FLEN - 1) begin
                check({nm, " cmd_valid"}, 32'(cmd_valid), 32'(good));
                check({nm, " frame_error"}, 32'(frame_error), 32'(!good));
            end else begin
                check({nm, " early cmd_valid"}, 32'(cmd_valid), 32'(0));
                check({nm, " early frame_error"}, 32'(frame_error), 32'(0));
            end
        end
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    typedef struct packed {
        logic [39:0] bytes;
        logic        good;
        logic [1:0]  code;
        logic [7:0]  op;
        logic [3:0]  x;
        logic [3:0]  y;
    } vec_t;

    function automatic logic [7:0] pick_coord();
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return 8'($urandom_range(0, G));
    endfunction

    function automatic int pick_gap();
        if ($urandom_range(0, 19) == 0) return $urandom_range(T - 1, T + 2);
        return $urandom_range(0, 2);
    endfunction

    initial begin
        vec_t vecs [9];
        logic [7:0] fb [5];
        int kind, nsend, gap;

`ifdef CMD_CHECKSUM_EN
        vecs[0] = '{40'hAA03040700, 1'b1, 2'b00, 8'h03, 4'h4, 4'h7};
        vecs[1] = '{40'hAA03040701, 1'b0, 2'b01, 8'h03, 4'h4, 4'h7};
        vecs[2] = '{40'hAA010A0209, 1'b0, 2'b10, 8'h03, 4'h4, 4'h7};
        vecs[3] = '{40'hAA05090905, 1'b1, 2'b10, 8'h05, 4'h9, 4'h9};
        vecs[4] = '{40'hAA02030A0B, 1'b0, 2'b10, 8'h05, 4'h9, 4'h9};
        vecs[5] = '{40'hAAAA0102A9, 1'b1, 2'b10, 8'hAA, 4'h1, 4'h2};
        vecs[6] = '{40'hAA10130003, 1'b0, 2'b10, 8'hAA, 4'h1, 4'h2};
        vecs[7] = '{40'hAA07010200, 1'b0, 2'b01, 8'hAA, 4'h1, 4'h2};
        vecs[8] = '{40'hAA04000004, 1'b1, 2'b01, 8'h04, 4'h0, 4'h0};
`else
        vecs[0] = '{40'hAA03040700, 1'b1, 2'b00, 8'h03, 4'h4, 4'h7};
        vecs[1] = '{40'hAA03040701, 1'b1, 2'b00, 8'h03, 4'h4, 4'h7};
        vecs[2] = '{40'hAA010A0209, 1'b0, 2'b10, 8'h03, 4'h4, 4'h7};
        vecs[3] = '{40'hAA05090905, 1'b1, 2'b10, 8'h05, 4'h9, 4'h9};
        vecs[4] = '{40'hAA02030A0B, 1'b0, 2'b10, 8'h05, 4'h9, 4'h9};
        vecs[5] = '{40'hAAAA0102A9, 1'b1, 2'b10, 8'hAA, 4'h1, 4'h2};
        vecs[6] = '{40'hAA10130003, 1'b0, 2'b10, 8'hAA, 4'h1, 4'h2};
        vecs[7] = '{40'hAA07010200, 1'b1, 2'b10, 8'h07, 4'h1, 4'h2};
        vecs[8] = '{40'hAA04000004, 1'b1, 2'b10, 8'h04, 4'h0, 4'h0};
`endif

        // Reset state
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'hAA);
        check("reset cmd_valid", 32'(cmd_valid), 32'(0));
        check("reset frame_error", 32'(frame_error), 32'(0));
        check("reset cmd_op", 32'(cmd_op), 32'(0));
        check("reset cmd_x", 32'(cmd_x), 32'(0));
        check("reset cmd_y", 32'(cmd_y), 32'(0));
        check("reset err_code", 32'(err_code), 32'(0));
        cycle(1'b0, 1'b0, 8'h00);

        // Table vectors
        for (int k = 0; k < 9; k++) begin
            send_vec(vecs[k].bytes, vecs[k].good, $sformatf("vec%0d", k));
            check($sformatf("vec%0d cmd_op", k), 32'(cmd_op), 32'(vecs[k].op));
            check($sformatf("vec%0d cmd_x", k), 32'(cmd_x), 32'(vecs[k].x));
            check($sformatf("vec%0d cmd_y", k), 32'(cmd_y), 32'(vecs[k].y));
            check($sformatf("vec%0d err_code", k), 32'(err_code), 32'(vecs[k].code));
        end

        // Timeout: AA 01 then silence; error fires on the (T+1)th idle cycle
        cycle(1'b0, 1'b1, 8'hAA);
        cycle(1'b0, 1'b1, 8'h01);
        for (int k = 1; k <= T + 1; k++) begin
            cycle(1'b0, 1'b0, 8'h00);
            check($sformatf("timeout idle%0d frame_error", k), 32'(frame_error), 32'(k == T + 1));
            check($sformatf("timeout idle%0d cmd_valid", k), 32'(cmd_valid), 32'(0));
        end
        check("timeout err_code", 32'(err_code), 32'(2'b11));
        check("timeout keeps cmd_op", 32'(cmd_op), 32'(8'h04));
        send_vec(40'hAA03040700, 1'b1, "after_timeout");
        check("after_timeout cmd_op", 32'(cmd_op), 32'(8'h03));
        check("after_timeout cmd_y", 32'(cmd_y), 32'(4'h7));

        // Byte on the exact expiry cycle is accepted and parsing continues
        cycle(1'b0, 1'b1, 8'hAA);
        cycle(1'b0, 1'b1, 8'h01);
        for (int k = 1; k <= T; k++) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h02);
        check("race frame_error", 32'(frame_error), 32'(0));
        cycle(1'b0, 1'b1, 8'h03);
`ifdef CMD_CHECKSUM_EN
        cycle(1'b0, 1'b1, 8'h00);
`endif
        check("race cmd_valid", 32'(cmd_valid), 32'(1));
        check("race cmd_op", 32'(cmd_op), 32'(8'h01));
        check("race cmd_x", 32'(cmd_x), 32'(4'h2));
        check("race cmd_y", 32'(cmd_y), 32'(4'h3));
        cycle(1'b0, 1'b0, 8'h00);

        // Discard, partial frame, reset (with a coincident strobe), then a good frame
        cycle(1'b0, 1'b1, 8'h55);
        cycle(1'b0, 1'b1, 8'h12);
        cycle(1'b0, 1'b1, 8'hAA);
        cycle(1'b0, 1'b1, 8'h01);
        cycle(1'b1, 1'b1, 8'hAA);
        check("reset-mid frame_error", 32'(frame_error), 32'(0));
        check("reset-mid cmd_op", 32'(cmd_op), 32'(0));
        check("reset-mid err_code", 32'(err_code), 32'(0));
        cycle(1'b0, 1'b1, 8'h02);
        check("post-reset discard cmd_valid", 32'(cmd_valid), 32'(0));
        send_vec(40'hAA02010102, 1'b1, "post_reset");
        check("post_reset cmd_op", 32'(cmd_op), 32'(8'h02));
        check("post_reset cmd_x", 32'(cmd_x), 32'(4'h1));

        // Randomized frames against the model
        for (int f = 0; f < 250; f++) begin
            kind  = $urandom_range(0, 9);
            fb[0] = 8'hAA;
            fb[1] = 8'($urandom);
            fb[2] = pick_coord();
            fb[3] = pick_coord();
            fb[4] = fb[1] ^ fb[2] ^ fb[3];
            if (kind == 0) fb[4] = fb[4] ^ 8'($urandom_range(1, 255));
            nsend = (kind == 1) ? $urandom_range(1, FLEN - 1) : FLEN;
            if (kind == 2) begin
                for (int j = 0; j < 5; j++) fb[j] = 8'($urandom);
                nsend = 5;
            end
            for (int j = 0; j < nsend; j++) begin
                gap = pick_gap();
                for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 8'h00);
                if ($urandom_range(0, 60) == 0) cycle(1'b1, 1'($urandom_range(0, 1)), 8'hAA);
                cycle(1'b0, 1'b1, fb[j]);
            end
        end
        for (int k = 0; k < T + 3; k++) cycle(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
